// File: rtl/sorter_pkg.sv
// sorter_pkg: shared constants, state type and width helper for the sorter frame packer
// Ports: none (package)
package sorter_pkg;
   localparam logic [1023:0] PAD_ONES = '1;
   typedef enum logic {FILLING, PENDING} pack_state_e;
   function automatic int count_width(input int n);
      return $clog2(n) + 1;
   endfunction
endpackage

// File: rtl/sorter_frame_bank.sv
// sorter_frame_bank: N_LANES x DATA_WIDTH register bank with lane writes, pad fill and bulk load
// Ports: clock/reset (sync, active-high, clears all lanes); we_i/wdata_i per-lane write;
//        pad_en_i/pad_start_i/pad_value_i fill lanes >= pad_start_i; load_en_i/load_data_i bulk load;
//        data_o current bank contents
module sorter_frame_bank
   import sorter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_LANES = 8,
   localparam int CW = count_width(N_LANES)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_LANES-1:0]    we_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  pad_en_i,
   input  logic [CW-1:0]         pad_start_i,
   input  logic [DATA_WIDTH-1:0] pad_value_i,
   input  logic                  load_en_i,
   input  logic [DATA_WIDTH-1:0] load_data_i [N_LANES],
   output logic [DATA_WIDTH-1:0] data_o [N_LANES]
);
   logic [DATA_WIDTH-1:0] data_q [N_LANES];
   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      always_ff @(posedge clock)
         if (reset) data_q[i] <= '0;
         else if (load_en_i) data_q[i] <= load_data_i[i];
         else if (we_i[i]) data_q[i] <= wdata_i;
         else if (pad_en_i && CW'(i) >= pad_start_i) data_q[i] <= pad_value_i;
   end
   assign data_o = data_q;
endmodule

// File: rtl/sorter_frame_packer.sv
// sorter_frame_packer: packs a serial valid/ready sample stream into padded N_LANES-wide frames
// Ports: clock/reset (sync, active-high); in_data/in_valid/in_last/in_ready serial input;
//        out_data (lane 0 = first sample)/out_count (real lanes)/out_valid/out_ready frame output
module sorter_frame_packer
   import sorter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int N_LANES = 8,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE = PAD_ONES[DATA_WIDTH-1:0],
   localparam int PW = $clog2(N_LANES),
   localparam int CW = count_width(N_LANES)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data [N_LANES],
   output logic [CW-1:0]         out_count,
   output logic                  out_valid,
   input  logic                  out_ready
);
   pack_state_e state_q, state_d;
   logic [PW-1:0] fill_ptr_q, fill_ptr_d;
   logic [CW-1:0] pend_count_q, pend_count_d, out_count_q, out_count_d, close_count;
   logic out_valid_q, out_valid_d;
   logic pending, accept, close, drain_ok, xfer;
   logic [N_LANES-1:0] fill_we;
   logic [DATA_WIDTH-1:0] fill_data [N_LANES];
   logic [DATA_WIDTH-1:0] frame [N_LANES];
   assign pending = state_q == PENDING;
   assign in_ready = !pending;
   assign accept = in_valid && in_ready;
   assign close = accept && (in_last || fill_ptr_q == PW'(N_LANES - 1));
   assign close_count = CW'(fill_ptr_q) + CW'(1);
   assign drain_ok = !out_valid_q || out_ready;
   assign xfer = (close || pending) && drain_ok;
   assign fill_we = accept ? N_LANES'(1) << fill_ptr_q : '0;
   assign out_count = out_count_q;
   assign out_valid = out_valid_q;
   // A closing frame bypasses the fill register: the closing sample and pad lanes are merged in here
   // so the output bank can load it on the same edge; a pending frame is already complete in the fill bank.
   always_comb
      for (int i = 0; i < N_LANES; i++)
         frame[i] = pending ? fill_data[i] :
                    PW'(i) == fill_ptr_q ? in_data :
                    PW'(i) > fill_ptr_q ? PAD_VALUE : fill_data[i];
   always_comb begin
      fill_ptr_d = close ? '0 : accept ? fill_ptr_q + PW'(1) : fill_ptr_q;
      pend_count_d = close ? close_count : pend_count_q;
      out_valid_d = xfer || (out_valid_q && !out_ready);
      out_count_d = xfer ? (pending ? pend_count_q : close_count) : out_count_q;
      state_d = pending ? (xfer ? FILLING : PENDING) : (close && !drain_ok ? PENDING : FILLING);
   end
   always_ff @(posedge clock)
      if (reset) begin
         state_q <= FILLING;
         fill_ptr_q <= '0;
         pend_count_q <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_ptr_q <= fill_ptr_d;
         pend_count_q <= pend_count_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
      end
   sorter_frame_bank #(.DATA_WIDTH(DATA_WIDTH), .N_LANES(N_LANES)) u_fill_bank (
      .clock(clock),
      .reset(reset),
      .we_i(fill_we),
      .wdata_i(in_data),
      .pad_en_i(close),
      .pad_start_i(close_count),
      .pad_value_i(PAD_VALUE),
      .load_en_i(1'b0),
      .load_data_i(frame),
      .data_o(fill_data)
   );
   sorter_frame_bank #(.DATA_WIDTH(DATA_WIDTH), .N_LANES(N_LANES)) u_out_bank (
      .clock(clock),
      .reset(reset),
      .we_i('0),
      .wdata_i('0),
      .pad_en_i(1'b0),
      .pad_start_i('0),
      .pad_value_i(PAD_VALUE),
      .load_en_i(xfer),
      .load_data_i(frame),
      .data_o(out_data)
   );
endmodule

// File: tb/tb_sorter_frame_packer.sv
// tb_sorter_frame_packer: directed self-checking bench for 4- and 8-lane packer instances
module tb_sorter_frame_packer;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [31:0] in_data4, in_data8;
   logic in_valid4, in_last4, out_ready4, in_ready4, out_valid4;
   logic in_valid8, in_last8, out_ready8, in_ready8, out_valid8;
   logic [31:0] out_data4 [4];
   logic [31:0] out_data8 [8];
   logic [2:0] out_count4;
   logic [3:0] out_count8;
   int n_cmp = 0;
   int n_err = 0;
   always #5 clock = ~clock;
   sorter_frame_packer #(.DATA_WIDTH(32), .N_LANES(4)) u_dut4 (
      .clock(clock), .reset(reset), .in_data(in_data4), .in_valid(in_valid4), .in_last(in_last4),
      .in_ready(in_ready4), .out_data(out_data4), .out_count(out_count4), .out_valid(out_valid4),
      .out_ready(out_ready4)
   );
   sorter_frame_packer #(.DATA_WIDTH(32), .N_LANES(8)) u_dut8 (
      .clock(clock), .reset(reset), .in_data(in_data8), .in_valid(in_valid8), .in_last(in_last8),
      .in_ready(in_ready8), .out_data(out_data8), .out_count(out_count8), .out_valid(out_valid8),
      .out_ready(out_ready8)
   );
   task automatic step();
      @(posedge clock);
      #1;
   endtask
   task automatic idle();
      in_valid4 = 0; in_last4 = 0; in_data4 = '0; out_ready4 = 1;
      in_valid8 = 0; in_last8 = 0; in_data8 = '0; out_ready8 = 1;
   endtask
   task automatic test_reset();
      idle();
      reset = 1; in_valid8 = 1; in_data8 = 32'hdead;
      step(); step();
      if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL reset_valid4 got %b want 0", out_valid4); end n_cmp++;
      if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL reset_valid8 got %b want 0", out_valid8); end n_cmp++;
      if (out_count4 !== 3'd0) begin n_err++; $display("FAIL reset_count4 got %0d want 0", out_count4); end n_cmp++;
      if (out_count8 !== 4'd0) begin n_err++; $display("FAIL reset_count8 got %0d want 0", out_count8); end n_cmp++;
      for (int i = 0; i < 8; i++) begin
         if (out_data8[i] !== 32'd0) begin n_err++; $display("FAIL reset_lane8[%0d] got %h want 0", i, out_data8[i]); end n_cmp++;
      end
      reset = 0; in_valid8 = 0;
      step();
      if (in_ready4 !== 1'b1) begin n_err++; $display("FAIL post_reset_ready4 got %b want 1", in_ready4); end n_cmp++;
      if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL post_reset_ready8 got %b want 1", in_ready8); end n_cmp++;
      if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL post_reset_valid8 got %b want 0", out_valid8); end n_cmp++;
   endtask
   task automatic test_full_frame();
      idle();
      for (int k = 0; k < 4; k++) begin
         in_valid4 = 1; in_data4 = 32'(k);
         step();
         if (k < 3) begin
            if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL full_early_valid k=%0d got %b want 0", k, out_valid4); end n_cmp++;
         end
      end
      in_valid4 = 0;
      if (out_valid4 !== 1'b1) begin n_err++; $display("FAIL full_valid got %b want 1", out_valid4); end n_cmp++;
      if (out_count4 !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", out_count4); end n_cmp++;
      for (int i = 0; i < 4; i++) begin
         if (out_data4[i] !== 32'(i)) begin n_err++; $display("FAIL full_lane[%0d] got %h want %h", i, out_data4[i], 32'(i)); end n_cmp++;
      end
      step();
      if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL full_drain got %b want 0", out_valid4); end n_cmp++;
   endtask
   task automatic test_partial();
      logic [31:0] v [3];
      v = '{32'd5, 32'd9, 32'd2};
      idle();
      for (int k = 0; k < 3; k++) begin
         in_valid8 = 1; in_data8 = v[k]; in_last8 = (k == 2);
         step();
      end
      in_valid8 = 0; in_last8 = 0;
      if (out_valid8 !== 1'b1) begin n_err++; $display("FAIL part_valid got %b want 1", out_valid8); end n_cmp++;
      if (out_count8 !== 4'd3) begin n_err++; $display("FAIL part_count got %0d want 3", out_count8); end n_cmp++;
      for (int i = 0; i < 8; i++) begin
         if (out_data8[i] !== (i < 3 ? v[i] : 32'hFFFF_FFFF)) begin n_err++; $display("FAIL part_lane[%0d] got %h want %h", i, out_data8[i], (i < 3 ? v[i] : 32'hFFFF_FFFF)); end n_cmp++;
      end
      step();
      if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL part_drain got %b want 0", out_valid8); end n_cmp++;
      in_valid8 = 1; in_data8 = 32'd7; in_last8 = 1;
      step();
      in_valid8 = 0; in_last8 = 0;
      if (out_count8 !== 4'd1) begin n_err++; $display("FAIL part_next_count got %0d want 1", out_count8); end n_cmp++;
      if (out_data8[0] !== 32'd7) begin n_err++; $display("FAIL part_next_lane0 got %h want 7", out_data8[0]); end n_cmp++;
      if (out_data8[1] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL part_next_lane1 got %h want ffffffff", out_data8[1]); end n_cmp++;
      step();
   endtask
   task automatic test_backpressure();
      idle();
      out_ready4 = 0;
      for (int k = 0; k < 8; k++) begin
         if (in_ready4 !== 1'b1) begin n_err++; $display("FAIL bp_ready_in k=%0d got %b want 1", k, in_ready4); end n_cmp++;
         in_valid4 = 1; in_data4 = 32'(10 + k);
         step();
      end
      in_valid4 = 0;
      if (in_ready4 !== 1'b0) begin n_err++; $display("FAIL bp_ready_pending got %b want 0", in_ready4); end n_cmp++;
      step(); step();
      if (out_valid4 !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid got %b want 1", out_valid4); end n_cmp++;
      if (in_ready4 !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready got %b want 0", in_ready4); end n_cmp++;
      for (int i = 0; i < 4; i++) begin
         if (out_data4[i] !== 32'(10 + i)) begin n_err++; $display("FAIL bp_first_lane[%0d] got %0d want %0d", i, out_data4[i], 10 + i); end n_cmp++;
      end
      out_ready4 = 1;
      step();
      if (out_valid4 !== 1'b1) begin n_err++; $display("FAIL bp_second_valid got %b want 1", out_valid4); end n_cmp++;
      if (in_ready4 !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got %b want 1", in_ready4); end n_cmp++;
      if (out_count4 !== 3'd4) begin n_err++; $display("FAIL bp_second_count got %0d want 4", out_count4); end n_cmp++;
      for (int i = 0; i < 4; i++) begin
         if (out_data4[i] !== 32'(14 + i)) begin n_err++; $display("FAIL bp_second_lane[%0d] got %0d want %0d", i, out_data4[i], 14 + i); end n_cmp++;
      end
      step();
      if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid4); end n_cmp++;
   endtask
   task automatic test_back_to_back();
      idle();
      out_ready4 = 0;
      for (int k = 0; k < 7; k++) begin
         in_valid4 = 1; in_data4 = 32'(20 + k);
         step();
         if (k >= 3) begin
            if (out_valid4 !== 1'b1) begin n_err++; $display("FAIL b2b_hold_valid k=%0d got %b want 1", k, out_valid4); end n_cmp++;
         end
      end
      in_data4 = 32'd27; out_ready4 = 1;
      step();
      in_valid4 = 0; out_ready4 = 0;
      if (out_valid4 !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b want 1", out_valid4); end n_cmp++;
      if (in_ready4 !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", in_ready4); end n_cmp++;
      for (int i = 0; i < 4; i++) begin
         if (out_data4[i] !== 32'(24 + i)) begin n_err++; $display("FAIL b2b_lane[%0d] got %0d want %0d", i, out_data4[i], 24 + i); end n_cmp++;
      end
      out_ready4 = 1;
      step();
      if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", out_valid4); end n_cmp++;
   endtask
   task automatic test_reset_mid();
      idle();
      for (int k = 0; k < 3; k++) begin
         in_valid8 = 1; in_data8 = 32'(100 + k);
         step();
      end
      in_valid8 = 0; reset = 1;
      step();
      if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b want 0", out_valid8); end n_cmp++;
      if (out_count8 !== 4'd0) begin n_err++; $display("FAIL rmid_count got %0d want 0", out_count8); end n_cmp++;
      for (int i = 0; i < 8; i++) begin
         if (out_data8[i] !== 32'd0) begin n_err++; $display("FAIL rmid_lane[%0d] got %h want 0", i, out_data8[i]); end n_cmp++;
      end
      reset = 0;
      for (int k = 0; k < 8; k++) begin
         in_valid8 = 1; in_data8 = 32'(k);
         step();
         if (k < 7) begin
            if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL rmid_early_valid k=%0d got %b want 0", k, out_valid8); end n_cmp++;
         end
      end
      in_valid8 = 0;
      if (out_valid8 !== 1'b1) begin n_err++; $display("FAIL rmid_frame_valid got %b want 1", out_valid8); end n_cmp++;
      if (out_count8 !== 4'd8) begin n_err++; $display("FAIL rmid_frame_count got %0d want 8", out_count8); end n_cmp++;
      for (int i = 0; i < 8; i++) begin
         if (out_data8[i] !== 32'(i)) begin n_err++; $display("FAIL rmid_frame_lane[%0d] got %h want %h", i, out_data8[i], 32'(i)); end n_cmp++;
      end
      step();
   endtask
   task automatic test_last_gaps();
      idle();
      for (int k = 0; k < 4; k++) begin
         in_valid4 = 1; in_data4 = 32'(40 + k); in_last4 = (k == 3);
         step();
         if (k == 3) begin
            if (out_valid4 !== 1'b1) begin n_err++; $display("FAIL gap_valid got %b want 1", out_valid4); end n_cmp++;
            if (out_count4 !== 3'd4) begin n_err++; $display("FAIL gap_count got %0d want 4", out_count4); end n_cmp++;
            for (int i = 0; i < 4; i++) begin
               if (out_data4[i] !== 32'(40 + i)) begin n_err++; $display("FAIL gap_lane[%0d] got %0d want %0d", i, out_data4[i], 40 + i); end n_cmp++;
            end
         end else begin
            if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL gap_early_valid k=%0d got %b want 0", k, out_valid4); end n_cmp++;
         end
         in_valid4 = 0; in_last4 = 1; in_data4 = 32'hbad;
         step();
         if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL gap_idle_valid k=%0d got %b want 0", k, out_valid4); end n_cmp++;
      end
      in_last4 = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_full_frame();
      test_partial();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_last_gaps();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sorter_frame_packer.md
Name: sorter_frame_packer

Overview:
- Upstream feeder for the batcher sorter network (4- and 8-lane instances).
- Accepts a serial valid/ready sample stream and packs N_LANES consecutive samples into one parallel frame.
- Partial frames, terminated by in_last, are padded so padding sorts to the top lanes.
- Double-buffered, so input keeps flowing while a completed frame waits for the sorter side.

Parameters:
- DATA_WIDTH, 32, width of each sample.
- N_LANES, 8, frame size; must be a power of two, 2..64.
- PAD_VALUE, all ones of DATA_WIDTH, value written into unfilled lanes of a partial frame.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_WIDTH  input sample.
- in_valid  in  1  sample valid.
- in_last  in  1  qualifies the current sample as the final one of a frame; forces an early close.
- in_ready  out  1  packer can accept a sample.
- out_data  out  DATA_WIDTH x N_LANES (unpacked array, index 0 = first sample received)  frame to sorter.
- out_count  out  $clog2(N_LANES)+1  number of real (non-pad) lanes in out_data.
- out_valid  out  1  frame valid.
- out_ready  in  1  sorter side accepts the frame.

Behaviour:
- Clocking and reset: one clock domain, clock. Reset is synchronous and active-high. Reset clears fill_ptr, pending, out_valid, out_count and all out_data lanes to 0. in_ready is 1 during the cycle after reset deasserts.
- Sample acceptance: a sample is accepted on a rising edge with in_valid && in_ready. It is written to fill-bank lane fill_ptr, and fill_ptr increments.
- Frame close: a frame closes on acceptance when fill_ptr == N_LANES-1 or in_last == 1. On close, lanes fill_ptr+1..N_LANES-1 load PAD_VALUE, count = fill_ptr+1, and fill_ptr returns to 0.
- Transfer to the output register: a closed frame moves to the output register in the same edge if the output register is empty (!out_valid) or is being drained (out_valid && out_ready). Otherwise the frame stays in the fill bank and pending is set.
- Latency: from the closing sample's accepting edge, out_valid is high in the next cycle.
- Backpressure: in_ready = !pending.
- Pending frame: while pending, on the edge with out_valid && out_ready the pending frame transfers, out_valid stays 1 (back-to-back frames), and pending clears. in_ready returns to 1 in the following cycle.
- Drain without replacement: out_valid && out_ready with no frame ready clears out_valid next cycle.
- Output stability: out_data and out_count hold stable while out_valid && !out_ready.
- in_last at fill_ptr == N_LANES-1: closes normally with count = N_LANES and no padding.
- in_last without in_valid: ignored.
- Simultaneous close and drain: transfer happens and out_valid stays high; no bubble.
- Reset mid-frame or with pending: partial or pending data is discarded. No frame is emitted for it.
- Arithmetic: fill_ptr is $clog2(N_LANES) bits and never wraps past N_LANES-1. out_count ranges 1..N_LANES, and N_LANES is representable.

Decomposition:
- Shared package sorter_pkg holds:
  - default PAD constant;
  - helper function for the count width ($clog2(N)+1);
  - enum for the packer state: FILLING, PENDING.
- One sub-module: sorter_frame_bank. It is a single N_LANES x DATA_WIDTH register bank with:
  - per-lane write enable;
  - bulk pad-fill from a start index;
  - bulk load from a sibling bank.
- The packer instantiates it twice (fill bank, output bank).

Test Plan:
- Full frame, always ready: N_LANES=4, out_ready=1, send 0,1,2,3 with in_last=0 → one cycle after accepting 3, out_valid=1 for one cycle, out_data={0,1,2,3}, out_count=4.
- Partial frame: N_LANES=8, send 5,9,2 with in_last on 2 → out_data={5,9,2,FFFFFFFF x5}, out_count=3; the next frame starts at lane 0.
- Backpressure and pending: N_LANES=4, out_ready=0, send 8 samples 10..17 → first frame {10..13} held on out_data. After sample 17, in_ready=0. Raise out_ready → frames {10..13} then {14..17} on consecutive cycles, out_valid continuous; in_ready returns to 1 after the second transfer.
- Simultaneous close and drain: out_valid=1 and out_ready pulsed on the same edge the next frame closes → new frame on out_data next cycle, out_valid never drops.
- Reset mid-operation: N_LANES=8, 3 samples accepted, reset high one cycle, then send 0..7 → a single frame {0..7}; no stale lanes; out_valid=0 and out_data all 0 during reset.
- in_last on the final lane plus idle gaps: in_valid toggled every other cycle across 4 samples with in_last on the 4th (N_LANES=4) → out_count=4, no pad, data order preserved.
